// File: rtl/t_counter_ctrl.sv
// t_counter_ctrl: run controller around an 8-bit T-flip-flop counter.
// It sequences timed runs with a programmable prescaler, a programmable
// terminal count, one-shot or periodic restart, pause and abort.

// T_counter: 8-bit ripple-style T-flip-flop counter. Bit i toggles when T is
// high and every lower bit is 1, so the word increments by one per T cycle.
module T_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       t,
  output logic [7:0] q
);

  logic [7:0] tgl;

  // Build the toggle mask: each stage toggles only when all lower stages are 1
  always_comb begin
    tgl[0] = t;
    for (int i = 1; i < 8; i++) begin
      tgl[i] = tgl[i-1] & q[i-1];
    end
  end

  // The T flip-flops themselves; the reset is asynchronous
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= 8'd0;
    end else begin
      q <= q ^ tgl;
    end
  end

endmodule

module t_counter_ctrl #(
  parameter int PRESC_W = 4
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               periodic,
  input  logic [7:0]         terminal,
  input  logic [PRESC_W-1:0] prescale,
  output logic [7:0]         count,
  output logic               busy,
  output logic               tick,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               load_cfg;
  logic               clr_q;
  logic               cnt_rst;
  logic               term_hit;
  logic [7:0]         term_q;
  logic [PRESC_W-1:0] presc_q;
  logic               per_q;
  logic [PRESC_W-1:0] pc;

  // The counter clears on the block reset or for the single CLEAR cycle;
  // clr_q is a flop so the clear pulse carries no combinational glitches.
  assign cnt_rst = Reset | clr_q;

  T_counter u_cnt (
    .clk   (CLK),
    .reset (cnt_rst),
    .t     (tick),
    .q     (count)
  );

  assign term_hit = (count == term_q);

  // Status and strobe outputs; a tick is withheld at the terminal value so
  // the counter never wraps, and no done is reported on an abort edge
  always_comb begin
    busy = (state_q == S_CLEAR) || (state_q == S_RUN);
    tick = (state_q == S_RUN) && !pause && (pc == presc_q) && !term_hit;
    done = (state_q == S_RUN) && term_hit && !stop;
  end

  // Next-state logic; stop outranks both a new start and a terminal hit
  always_comb begin
    state_d  = state_q;
    load_cfg = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_CLEAR;
          load_cfg = 1'b1;
        end
      end
      S_CLEAR: begin
        if (stop) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (term_hit) begin
          state_d = per_q ? S_CLEAR : S_DONE;
        end
      end
      S_DONE: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (start) begin
          state_d  = S_CLEAR;
          load_cfg = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Clear pulse: high exactly during cycles spent in CLEAR
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      clr_q <= 1'b0;
    end else begin
      clr_q <= (state_d == S_CLEAR);
    end
  end

  // Run configuration is captured only on an accepted start
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      term_q  <= 8'd0;
      presc_q <= '0;
      per_q   <= 1'b0;
    end else if (load_cfg) begin
      term_q  <= terminal;
      presc_q <= prescale;
      per_q   <= periodic;
    end
  end

  // Prescaler: counts unpaused RUN cycles and wraps when a tick is issued
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pc <= '0;
    end else if (state_q == S_CLEAR) begin
      pc <= '0;
    end else if ((state_q == S_RUN) && !pause && !term_hit) begin
      if (pc == presc_q) begin
        pc <= '0;
      end else begin
        pc <= pc + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_t_counter_ctrl.sv
// tb_t_counter_ctrl: directed, table-driven bench for the T-counter run
// controller, with hand-written sequences for the multi-cycle corners.
module tb_t_counter_ctrl;

  logic       CLK;
  logic       Reset;
  logic       start;
  logic       stop;
  logic       pause;
  logic       periodic;
  logic [7:0] terminal;
  logic [3:0] prescale;
  logic [7:0] count;
  logic       busy;
  logic       tick;
  logic       done;

  int totalCount;
  int badCount;

  typedef struct {
    logic       start;
    logic       stop;
    logic       pause;
    logic       periodic;
    logic [7:0] terminal;
    logic [3:0] prescale;
    logic [7:0] expCount;
    logic       expBusy;
    logic       expTick;
    logic       expDone;
  } vec_t;

  vec_t vq[$];

  t_counter_ctrl #(.PRESC_W(4)) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .periodic (periodic),
    .terminal (terminal),
    .prescale (prescale),
    .count    (count),
    .busy     (busy),
    .tick     (tick),
    .done     (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive one cycle of inputs just after the rising edge
  task automatic applyStimulus(input logic s, input logic sp, input logic p,
                               input logic per, input logic [7:0] term,
                               input logic [3:0] pre);
    @(posedge CLK);
    #1;
    start    = s;
    stop     = sp;
    pause    = p;
    periodic = per;
    terminal = term;
    prescale = pre;
  endtask

  // Compare all four outputs against the expected values
  task automatic checkOutput(input string nm, input logic [7:0] ec,
                             input logic eb, input logic et, input logic ed);
    totalCount++;
    if ({count, busy, tick, done} !== {ec, eb, et, ed}) begin
      badCount++;
      $display("[TB] FAIL %s: got count=%0d busy=%b tick=%b done=%b, want count=%0d busy=%b tick=%b done=%b",
               nm, count, busy, tick, done, ec, eb, et, ed);
    end
  endtask

  // Hold reset for two cycles and release it on a falling edge
  task automatic resetDut();
    Reset    = 1'b1;
    start    = 1'b0;
    stop     = 1'b0;
    pause    = 1'b0;
    periodic = 1'b0;
    terminal = 8'd0;
    prescale = 4'd0;
    @(negedge CLK);
    @(negedge CLK);
    Reset = 1'b0;
  endtask

  task automatic addVec(input logic s, input logic sp, input logic p,
                        input logic per, input logic [7:0] term,
                        input logic [3:0] pre, input logic [7:0] ec,
                        input logic eb, input logic et, input logic ed);
    vec_t v;
    v.start = s; v.stop = sp; v.pause = p; v.periodic = per;
    v.terminal = term; v.prescale = pre;
    v.expCount = ec; v.expBusy = eb; v.expTick = et; v.expDone = ed;
    vq.push_back(v);
  endtask

  initial begin
    logic [7:0] ec;
    logic       eb;
    logic       et;
    logic       ed;
    int         ph;
    int         rel;
    totalCount = 0;
    badCount   = 0;

    // One-shot terminal=5 prescale=0 from IDLE, then the pause repeat from DONE
    addVec(1,0,0,0,5,0, 0,0,0,0);
    addVec(0,0,0,0,5,0, 0,1,0,0);
    addVec(0,0,0,0,5,0, 0,1,1,0);
    addVec(0,0,0,0,5,0, 1,1,1,0);
    addVec(0,0,0,0,5,0, 2,1,1,0);
    addVec(0,0,0,0,5,0, 3,1,1,0);
    addVec(0,0,0,0,5,0, 4,1,1,0);
    addVec(0,0,0,0,5,0, 5,1,0,1);
    addVec(0,0,0,0,5,0, 5,0,0,0);
    addVec(0,0,0,0,5,0, 5,0,0,0);
    addVec(1,0,0,0,5,0, 5,0,0,0);
    addVec(0,0,0,0,5,0, 0,1,0,0);
    addVec(0,0,0,0,5,0, 0,1,1,0);
    addVec(0,0,1,0,5,0, 1,1,0,0);
    addVec(0,0,1,0,5,0, 1,1,0,0);
    addVec(0,0,1,0,5,0, 1,1,0,0);
    addVec(0,0,0,0,5,0, 1,1,1,0);
    addVec(0,0,0,0,5,0, 2,1,1,0);
    addVec(0,0,0,0,5,0, 3,1,1,0);
    addVec(0,0,0,0,5,0, 4,1,1,0);
    addVec(0,0,0,0,5,0, 5,1,0,1);
    addVec(0,0,0,0,5,0, 5,0,0,0);

    resetDut();
    checkOutput("resetState", 8'd0, 1'b0, 1'b0, 1'b0);

    foreach (vq[i]) begin
      applyStimulus(vq[i].start, vq[i].stop, vq[i].pause, vq[i].periodic,
                    vq[i].terminal, vq[i].prescale);
      @(negedge CLK);
      checkOutput($sformatf("vec%0d", i), vq[i].expCount, vq[i].expBusy,
                  vq[i].expTick, vq[i].expDone);
    end

    // Prescale=3 terminal=2: ticks in cycles 5 and 9, done in cycle 10
    resetDut();
    for (int c = 0; c <= 12; c++) begin
      applyStimulus(c == 0, 1'b0, 1'b0, 1'b0, 8'd2, 4'd3);
      @(negedge CLK);
      ec = (c < 6) ? 8'd0 : ((c < 10) ? 8'd1 : 8'd2);
      eb = (c >= 1) && (c <= 10);
      et = (c == 5) || (c == 9);
      ed = (c == 10);
      checkOutput($sformatf("presc3 c%0d", c), ec, eb, et, ed);
    end

    // Periodic terminal=3: done in cycles 5, 10, 15 with CLEAR after each
    resetDut();
    for (int c = 0; c <= 16; c++) begin
      applyStimulus(c == 0, 1'b0, 1'b0, 1'b1, 8'd3, 4'd0);
      @(negedge CLK);
      if (c == 0) begin
        ec = 0; eb = 0; et = 0; ed = 0;
      end else begin
        ph = (c - 1) % 5;
        eb = 1'b1;
        if (ph == 0) begin
          ec = 0; et = 0; ed = 0;
        end else if (ph == 4) begin
          ec = 3; et = 0; ed = 1;
        end else begin
          ec = 8'(ph - 1); et = 1; ed = 0;
        end
      end
      checkOutput($sformatf("periodic c%0d", c), ec, eb, et, ed);
    end

    // Abort with stop and start together in cycle 4, then a clean restart
    // in cycle 7; a start while busy (cycle 10, new terminal) is ignored
    resetDut();
    for (int c = 0; c <= 17; c++) begin
      applyStimulus((c == 0) || (c == 4) || (c == 7) || (c == 10), c == 4,
                    1'b0, 1'b0, (c >= 10) ? 8'd1 : 8'd5, 4'd0);
      @(negedge CLK);
      if (c < 7) begin
        if (c == 0) begin
          ec = 0; eb = 0; et = 0;
        end else if (c == 1) begin
          ec = 0; eb = 1; et = 0;
        end else if (c <= 4) begin
          ec = 8'(c - 2); eb = 1; et = 1;
        end else begin
          ec = 3; eb = 0; et = 0;
        end
        ed = 0;
      end else begin
        rel = c - 7;
        if (rel == 0) begin
          ec = 3; eb = 0; et = 0; ed = 0;
        end else if (rel == 1) begin
          ec = 0; eb = 1; et = 0; ed = 0;
        end else if (rel <= 6) begin
          ec = 8'(rel - 2); eb = 1; et = 1; ed = 0;
        end else if (rel == 7) begin
          ec = 5; eb = 1; et = 0; ed = 1;
        end else begin
          ec = 5; eb = 0; et = 0; ed = 0;
        end
      end
      checkOutput($sformatf("abort c%0d", c), ec, eb, et, ed);
    end

    // Asynchronous reset mid-run with count=4
    resetDut();
    for (int c = 0; c <= 6; c++) begin
      applyStimulus(c == 0, 1'b0, 1'b0, 1'b0, 8'd5, 4'd0);
    end
    @(negedge CLK);
    checkOutput("preReset c6", 8'd4, 1'b1, 1'b1, 1'b0);
    #1;
    Reset = 1'b1;
    #1;
    checkOutput("asyncReset", 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    Reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd5, 4'd0);
    @(negedge CLK);
    checkOutput("idleAfterReset", 8'd0, 1'b0, 1'b0, 1'b0);

    // Terminal=0 one-shot: done in cycle 2, never a tick
    resetDut();
    for (int c = 0; c <= 4; c++) begin
      applyStimulus(c == 0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd2);
      @(negedge CLK);
      checkOutput($sformatf("term0 c%0d", c), 8'd0,
                  (c == 1) || (c == 2), 1'b0, c == 2);
    end

    // Terminal=0 periodic: done every second cycle
    resetDut();
    for (int c = 0; c <= 7; c++) begin
      applyStimulus(c == 0, 1'b0, 1'b0, 1'b1, 8'd0, 4'd0);
      @(negedge CLK);
      checkOutput($sformatf("term0per c%0d", c), 8'd0, c >= 1, 1'b0,
                  (c >= 2) && (c % 2 == 0));
    end

    // Terminal=255: reaches 255 in cycle 257 and stays there
    resetDut();
    for (int c = 0; c <= 261; c++) begin
      applyStimulus(c == 0, 1'b0, 1'b0, 1'b0, 8'd255, 4'd0);
      @(negedge CLK);
      if (c == 0) begin
        ec = 0; eb = 0; et = 0; ed = 0;
      end else if (c == 1) begin
        ec = 0; eb = 1; et = 0; ed = 0;
      end else if (c <= 256) begin
        ec = 8'(c - 2); eb = 1; et = 1; ed = 0;
      end else if (c == 257) begin
        ec = 255; eb = 1; et = 0; ed = 1;
      end else begin
        ec = 255; eb = 0; et = 0; ed = 0;
      end
      checkOutput($sformatf("term255 c%0d", c), ec, eb, et, ed);
    end

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
